tpumac_pipe: RTL and testbench
==============================

// Module: tpumac_pipe
// PURPOSE
//  Pipelined, parametrised successor to the single-cycle systolic MAC cell.
//  Forwards A/B to neighbour cells, multiplies A*B through MUL_STAGES registers
//  and accumulates into Cout, with squash-on-load/clear and overflow detection.
//  Used as the processing element of the next-generation systolic array.
// PARAMETERS
//  BITS_AB     8   signed operand width of Ain/Bin/Aout/Bout
//  BITS_C      16  signed accumulator width; must satisfy BITS_C >= 2*BITS_AB
//  MUL_STAGES  2   product pipeline depth, legal range 1..4
// PORTS
//  clk    in   1           clock, all state updates on posedge
//  rst    in   1           synchronous reset, active-high
//  en     in   1           accept Ain/Bin this cycle (forward + issue product)
//  WrEn   in   1           load Cin into accumulator
//  clr    in   1           zero accumulator
//  Ain    in   BITS_AB     signed operand A
//  Bin    in   BITS_AB     signed operand B
//  Cin    in   BITS_C      signed accumulator load value
//  Aout   out  BITS_AB     registered Ain, to east neighbour
//  Bout   out  BITS_AB     registered Bin, to south neighbour
//  Cout   out  BITS_C      accumulator
//  busy   out  1           any valid product in flight
//  ovf    out  1           sticky accumulate overflow flag
// BEHAVIOUR
//  - Reset: one clk and rst is synchronous active-high; on rst=1 at posedge: Aout=Bout=0,
//    Cout=0, ovf=0, all pipeline valid bits=0 (busy=0). rst overrides all inputs.
//  - Forwarding: en=1 at edge k -> Aout/Bout=Ain/Bin after edge k; en=0 holds.
//    Latency 1 regardless of MUL_STAGES; unaffected by WrEn/clr.
//  - Product pipeline: MUL_STAGES stages of {valid, product[2*BITS_AB-1:0]};
//    stage 0 loads Ain*Bin (full signed product) with valid=en; pipeline advances
//    every cycle (no stall); bubbles carry valid=0.
//  - Accumulate: when last stage valid, Cout <= Cout + sext(product).
//    Operands issued at edge k reach Cout at edge k+MUL_STAGES.
//  - Priority at each edge: rst > clr > WrEn > accumulate.
//    clr: Cout=0, ovf=0. WrEn: Cout=Cin, ovf=0.
//    clr or WrEn squashes every in-flight product, including one issued by en
//    on the same edge (all valid bits forced 0); Aout/Bout still forward.
//  - busy = OR of all stage valid bits (combinational from registers).
//  - Arithmetic: sum formed at BITS_C+1 bits; overflow when the two top bits
//    differ. On overflow ovf<=1 (sticky until rst/clr/WrEn).
//  - Back-to-back: en held high issues one product per cycle; Cout updates every
//    cycle once pipeline full; no product lost or duplicated.
//  - Mid-operation rst: identical to power-on reset; in-flight products discarded.
// CONFIGURATION
//  TPUMAC_SAT_EN defined: overflowing sum clamps Cout to +(2^(BITS_C-1)-1) or
//    -2^(BITS_C-1) according to sum sign; ovf still set.
//  TPUMAC_SAT_EN undefined: Cout takes the wrapped low BITS_C bits of the sum;
//    ovf still set. All other behaviour identical.
// TESTING
//  1 rst=1 mid-stream with busy=1 -> next cycle Cout=0, Aout=Bout=0, busy=0, ovf=0.
//  2 MUL_STAGES=2, WrEn Cin=10, then en Ain=3,Bin=-4 at edge k -> Cout=10 until
//    edge k+2, then Cout=-2; Aout=3,Bout=-4 after edge k.
//  3 en high 4 cycles, (A,B)=(1,2),(3,4),(5,6),(7,8) from Cout=0 -> Cout steps
//    2,14,44,100 on consecutive cycles; busy drops MUL_STAGES cycles after last en.
//  4 Products in flight, WrEn Cin=5 with en=1 same edge -> Cout=5 and stays 5;
//    busy=0 next cycle; clr likewise gives Cout=0.
//  5 BITS_C=16, Cin=32767 load, then en A=1,B=1 -> wrap build: Cout=-32768, ovf=1;
//    TPUMAC_SAT_EN build: Cout=32767, ovf=1; then clr -> ovf=0.
//  6 Sweep MUL_STAGES=1..4 with random A/B/en vs golden model, incl. min values
//    A=B=-128 (product 16384) -> Cout matches model every cycle.

Source files
------------

// File: rtl/tpumac_pipe.sv
// Pipelined systolic MAC cell: forwards A/B, multiplies through MUL_STAGES registers, accumulates into Cout.
// Optional build macro TPUMAC_SAT_EN: saturate Cout on overflow instead of wrapping.
module tpumac_pipe #(
  parameter int unsigned BITS_AB    = 8,
  parameter int unsigned BITS_C     = 16,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic                      busy,
  output logic                      ovf
);

  localparam int unsigned PW   = 2 * BITS_AB;
  localparam int unsigned LAST = MUL_STAGES - 1;
  localparam int unsigned XW   = BITS_C + 1 - PW;

  logic [MUL_STAGES-1:0]    vld;
  logic signed [PW-1:0]     prod [MUL_STAGES];
  logic [PW-1:0]            mul_c;
  logic [BITS_C:0]          sum_c;
  logic                     sum_ovf_c;
  logic [BITS_C-1:0]        acc_c;
  logic                     squash_c;

  // Operands sign-extended to full product width, so the low PW bits are the signed product.
  assign mul_c     = {{BITS_AB{Ain[BITS_AB-1]}}, Ain} * {{BITS_AB{Bin[BITS_AB-1]}}, Bin};
  assign sum_c     = {Cout[BITS_C-1], Cout} + {{XW{prod[LAST][PW-1]}}, prod[LAST]};
  assign sum_ovf_c = sum_c[BITS_C] ^ sum_c[BITS_C-1];
  assign squash_c  = clr | WrEn;
  assign busy      = |vld;

`ifdef TPUMAC_SAT_EN
  // Clamp toward the sign of the true sum when it leaves the accumulator range.
  always_comb begin
    acc_c = sum_c[BITS_C-1:0];
    if (sum_ovf_c) begin
      acc_c = sum_c[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    end
  end
`else
  assign acc_c = sum_c[BITS_C-1:0];
`endif

  // Operand forwarding, product pipeline and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      Aout <= '0;
      Bout <= '0;
      Cout <= '0;
      ovf  <= 1'b0;
      vld  <= '0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        prod[i] <= '0;
      end
    end else begin
      if (en) begin
        Aout <= Ain;
        Bout <= Bin;
      end
      vld[0]  <= en & ~squash_c;
      prod[0] <= mul_c;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        vld[i]  <= vld[i-1] & ~squash_c;
        prod[i] <= prod[i-1];
      end
      if (clr) begin
        Cout <= '0;
        ovf  <= 1'b0;
      end else if (WrEn) begin
        Cout <= Cin;
        ovf  <= 1'b0;
      end else if (vld[LAST]) begin
        Cout <= acc_c;
        if (sum_ovf_c) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tpumac_pipe.sv
// Scoreboard bench: four tpumac_pipe instances (MUL_STAGES 1..4) share one random stream,
// checked each cycle against an issue-history reference model.
module tb_tpumac_pipe;

  localparam int NCYC = 4096;
  localparam int NDUT = 4;

  typedef struct packed {
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [15:0] c;
    logic               busy;
    logic               ovf;
  } obs_t;
  typedef obs_t [NDUT-1:0] obs4_t;

  logic clk = 1'b0;
  logic rst, en, wren, clr;
  logic signed [7:0]  ain, bin;
  logic signed [15:0] cin;
  logic signed [7:0]  aout [NDUT];
  logic signed [7:0]  bout [NDUT];
  logic signed [15:0] cout [NDUT];
  logic               busy_w [NDUT];
  logic               ovf_w [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .MUL_STAGES(g + 1)) u_dut (
      .clk(clk), .rst(rst), .en(en), .WrEn(wren), .clr(clr),
      .Ain(ain), .Bin(bin), .Cin(cin),
      .Aout(aout[g]), .Bout(bout[g]), .Cout(cout[g]), .busy(busy_w[g]), .ovf(ovf_w[g])
    );
  end

  // Reference model: a product issued at edge k lands at edge k+S unless any
  // rst/clr/WrEn occurred at an edge in [k, k+S].
  bit    en_hist [NCYC];
  int    prod_hist [NCYC];
  int    last_kill = -1;
  int    cyc = 0;
  int    c_m [NDUT];
  bit    ovf_m [NDUT];
  logic signed [7:0] a_m, b_m;
  obs4_t exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_edge(input bit i_en, i_wr, i_clr, i_rst,
                            input logic signed [7:0] av, bv, input logic signed [15:0] cv);
    obs4_t e;
    int j;
    j = cyc;
    if (i_rst) begin
      a_m = 0; b_m = 0;
      en_hist[j] = 1'b0;
      last_kill = j;
      for (int d = 0; d < NDUT; d++) begin c_m[d] = 0; ovf_m[d] = 1'b0; end
    end else begin
      if (i_en) begin a_m = av; b_m = bv; end
      en_hist[j]   = i_en;
      prod_hist[j] = int'(av) * int'(bv);
      if (i_wr || i_clr) last_kill = j;
      for (int d = 0; d < NDUT; d++) begin
        int k, sum;
        k = j - (d + 1);
        if (i_clr) begin
          c_m[d] = 0; ovf_m[d] = 1'b0;
        end else if (i_wr) begin
          c_m[d] = int'(cv); ovf_m[d] = 1'b0;
        end else if (k >= 0 && en_hist[k] && last_kill < k) begin
          sum = c_m[d] + prod_hist[k];
          if (sum > 32767) begin
            ovf_m[d] = 1'b1;
`ifdef TPUMAC_SAT_EN
            sum = 32767;
`else
            sum = sum - 65536;
`endif
          end else if (sum < -32768) begin
            ovf_m[d] = 1'b1;
`ifdef TPUMAC_SAT_EN
            sum = -32768;
`else
            sum = sum + 65536;
`endif
          end
          c_m[d] = sum;
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      bit bz;
      bz = 1'b0;
      for (int k = j - d; k <= j; k++) begin
        if (k >= 0 && en_hist[k] && last_kill < k) bz = 1'b1;
      end
      e[d].a    = a_m;
      e[d].b    = b_m;
      e[d].c    = 16'(c_m[d]);
      e[d].busy = bz;
      e[d].ovf  = ovf_m[d];
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  // Drive one cycle of inputs, then record the expected post-edge state.
  task automatic step(input bit i_en, i_wr, i_clr, i_rst, input int a, b, c);
    logic signed [7:0]  av, bv;
    logic signed [15:0] cv;
    av = 8'(a); bv = 8'(b); cv = 16'(c);
    rst = i_rst; en = i_en; wren = i_wr; clr = i_clr;
    ain = av; bin = bv; cin = cv;
    @(posedge clk);
    model_edge(i_en, i_wr, i_clr, i_rst, av, bv, cv);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  function automatic int rnd_op();
    if ($urandom_range(9) == 0) return -128;
    return int'($urandom_range(255)) - 128;
  endfunction

  // Monitor: every cycle the DUTs present state; compare with the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs4_t e;
      obs_t  act;
      e = exp_q.pop_front();
      for (int d = 0; d < NDUT; d++) begin
        act = {aout[d], bout[d], cout[d], busy_w[d], ovf_w[d]};
        n_checks++;
        if (act === e[d]) n_pass++;
        else $display("FAIL S=%0d t=%0t got A=%0d B=%0d C=%0d busy=%b ovf=%b expected A=%0d B=%0d C=%0d busy=%b ovf=%b",
                      d + 1, $time, act.a, act.b, act.c, act.busy, act.ovf,
                      e[d].a, e[d].b, e[d].c, e[d].busy, e[d].ovf);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; wren = 1'b0; clr = 1'b0; ain = '0; bin = '0; cin = '0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 9, 9, 9);
    // Load 10, then a single 3*-4 product.
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3, -4, 0);
    idle(5);
    // Back-to-back products from zero.
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3, 4, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5, 6, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7, 8, 0);
    idle(5);
    // Squash in-flight products with WrEn and with clr, each with en on the same edge.
    step(1'b1, 1'b0, 1'b0, 1'b0, 11, 12, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, -13, 14, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 15, 16, 5);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 20, 21, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 22, 23, 0);
    idle(5);
    // Overflow at the positive limit, then clr drops the sticky flag.
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32767);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(2);
    // Negative overflow and minimum operands.
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -32768);
    step(1'b1, 1'b0, 1'b0, 1'b0, -1, 1, 0);
    idle(5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, -128, -128, 0);
    idle(5);
    // Reset mid-stream while busy.
    step(1'b1, 1'b0, 1'b0, 1'b0, 50, -60, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, -70, 80, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 90, 100, 0);
    idle(3);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      bit ren, rwr, rclr, rrst;
      r    = int'($urandom_range(99));
      ren  = ($urandom_range(9) < 7);
      rrst = (r == 0);
      rclr = (r >= 1 && r <= 2);
      rwr  = (r >= 3 && r <= 5);
      step(ren, rwr, rclr, rrst, rnd_op(), rnd_op(), int'($urandom_range(65535)) - 32768);
    end
    idle(5);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
